// File: rtl/dtw_core_ctrl_v2.sv
// dtw_core_ctrl_v2: sequences one query per run (cfg/start in, FWFT source FIFO in, datapath control, ref address out) and emits a 4-word result packet to the sink FIFO
module dtw_core_ctrl_v2 #(
  parameter int WIDTH = 16,
  parameter int AXIS_WIDTH = 32,
  parameter int MAX_SQG = 1024,
  parameter int SQG_PTR_WIDTH = 11,
  parameter int REFMEM_PTR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rs,
  input  logic                        abort,
  input  logic [SQG_PTR_WIDTH-1:0]    sqg_len,
  input  logic [WIDTH-1:0]            threshold,
  input  logic                        ref_load_done,
  output logic                        busy,
  output logic                        err_cfg,
  output logic                        src_fifo_rden,
  input  logic                        src_fifo_empty,
  input  logic [AXIS_WIDTH-1:0]       src_fifo_data,
  output logic                        sink_fifo_wren,
  input  logic                        sink_fifo_full,
  output logic [AXIS_WIDTH-1:0]       sink_fifo_data,
  output logic                        sink_fifo_last,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
  output logic                        dp_rst,
  output logic                        dp_running,
  input  logic                        dp_done,
  input  logic [WIDTH-1:0]            dp_minval,
  input  logic [AXIS_WIDTH-1:0]       dp_position,
  output logic [AXIS_WIDTH-1:0]       nquery
);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, RUN, DRAIN, EMIT} state_t;
  state_t state, nxt;
  logic [SQG_PTR_WIDTH-1:0] len, cnt;
  logic [WIDTH-1:0] thr, minval;
  logic [AXIS_WIDTH-1:0] qid, position;
  logic [REFMEM_PTR_WIDTH-1:0] addr, addr_inc;
  logic [1:0] widx;
  logic ab, hit, cfg_ok, start, pop, last_pop;
  assign cfg_ok = sqg_len != '0 && sqg_len <= SQG_PTR_WIDTH'(MAX_SQG);
  assign start = state == IDLE && rs && ref_load_done;
  assign pop = (state == HDR || state == LOAD || state == DRAIN) && !src_fifo_empty;
  assign last_pop = pop && cnt == len - SQG_PTR_WIDTH'(1);
  assign addr_inc = &addr ? addr : addr + REFMEM_PTR_WIDTH'(1);
  assign hit = !ab && minval <= thr;
  assign busy = state != IDLE;
  assign dp_rst = state == IDLE;
  assign src_fifo_rden = pop;
  assign dp_running = state == RUN || (state == LOAD && !src_fifo_empty);
  assign sink_fifo_wren = state == EMIT && !sink_fifo_full;
  assign sink_fifo_last = state == EMIT && widx == 2'd3;
  assign sink_fifo_data = state != EMIT ? '0 :
                          widx == 2'd0  ? qid :
                          widx == 2'd1  ? position :
                          widx == 2'd2  ? AXIS_WIDTH'(minval) : AXIS_WIDTH'({ab, hit});
  assign ref_addr_out = addr;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start && cfg_ok ? HDR : IDLE;
      HDR:   nxt = pop ? LOAD : HDR;
      LOAD:  nxt = abort ? (last_pop ? EMIT : DRAIN) : (last_pop ? RUN : LOAD);
      RUN:   nxt = dp_done || abort ? EMIT : RUN;
      DRAIN: nxt = last_pop ? EMIT : DRAIN;
      EMIT:  nxt = sink_fifo_wren && widx == 2'd3 ? IDLE : EMIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      len <= '0;
      thr <= '0;
      qid <= '0;
      cnt <= '0;
      addr <= '0;
      minval <= '0;
      position <= '0;
      ab <= 1'b0;
      widx <= '0;
      nquery <= '0;
      err_cfg <= 1'b0;
    end else begin
      err_cfg <= start && !cfg_ok;
      case (state)
        IDLE: begin
          addr <= '0;
          widx <= '0;
          if (start && cfg_ok) begin
            len <= sqg_len;
            thr <= threshold;
            ab <= 1'b0;
          end
        end
        HDR: if (pop) begin
          qid <= src_fifo_data;
          cnt <= '0;
        end
        LOAD: begin
          if (pop) begin
            cnt <= cnt + SQG_PTR_WIDTH'(1);
            addr <= addr_inc;
          end
          if (abort) begin
            ab <= 1'b1;
            minval <= '1;
            position <= '0;
          end
        end
        RUN: begin
          addr <= addr_inc;
          if (dp_done || abort) begin
            minval <= dp_minval;
            position <= dp_position;
            ab <= !dp_done;
          end
        end
        DRAIN: if (pop) cnt <= cnt + SQG_PTR_WIDTH'(1);
        EMIT: if (sink_fifo_wren) begin
          widx <= widx + 2'd1;
          if (widx == 2'd3) nquery <= nquery + AXIS_WIDTH'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: doc/dtw_core_ctrl_v2.md
Name: dtw_core_ctrl_v2

Overview:
Second-generation DTW core controller. Sequences one query per run between the source FIFO, the reference memory and an external dtw_core_datapath instance, then serialises a result packet to the sink FIFO. Compared with the first-generation controller it adds:
- runtime query length
- a match-threshold flag
- an abort path that keeps FIFO framing intact
- a flags word in the result packet
- backpressure-correct output handshake

Parameters:
WIDTH, 16, sample/score width
AXIS_WIDTH, 32, FIFO word and config width
MAX_SQG, 1024, largest legal query length
SQG_PTR_WIDTH, 11, width of query sample counter (must hold MAX_SQG)
REFMEM_PTR_WIDTH, 20, reference address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs  in  1  start request, sampled in IDLE
abort  in  1  abort current query (pulse)
sqg_len  in  SQG_PTR_WIDTH  samples per query, sampled at start
threshold  in  WIDTH  hit threshold, sampled at start
ref_load_done  in  1  reference memory ready
busy  out  1  high in every state except IDLE
err_cfg  out  1  1-cycle pulse on rejected start
src_fifo_rden  out  1  pop FWFT source FIFO
src_fifo_empty  in  1  source FIFO empty
src_fifo_data  in  32  qid word then samples in [WIDTH-1:0]
sink_fifo_wren  out  1  sink write
sink_fifo_full  in  1  sink full
sink_fifo_data  out  32  result word
sink_fifo_last  out  1  marks final packet word
ref_addr_out  out  REFMEM_PTR_WIDTH  reference address
dp_rst  out  1  datapath reset
dp_running  out  1  datapath advance enable
dp_done  in  1  datapath finished
dp_minval  in  WIDTH  datapath best score
dp_position  in  32  datapath best position
nquery  out  32  completed-packet counter

Behaviour:
Reset:
- Synchronous reset forces state IDLE.
- All outputs are 0 except dp_rst, which is 1.
- nquery, qid, flags and counters clear to 0.
- Reset mid-operation abandons the query immediately; no packet is emitted.

FSM: IDLE, HDR, LOAD, RUN, DRAIN, EMIT.

IDLE:
- dp_rst=1, addr=0.
- On rs with ref_load_done=1: if 1<=sqg_len<=MAX_SQG, latch sqg_len and threshold and go to HDR. Otherwise pulse err_cfg for 1 cycle and stay in IDLE.
- rs with ref_load_done=0 is ignored.

HDR:
- dp_rst=0.
- When !empty: rden=1 for that cycle, qid<=src_fifo_data, cnt<=0, go to LOAD.

LOAD:
- Cycle with !empty: rden=1, dp_running=1, addr++, cnt++.
- Cycle with empty: rden=0, dp_running=0, addr holds.
- When the sample with cnt==sqg_len-1 is consumed, go to RUN.

RUN:
- rden=0, dp_running=1, addr++ every cycle.
- addr saturates at all-ones; it does not wrap.
- On dp_done: latch minval and position, go to EMIT.

Abort handling:
- abort in LOAD: set flag ab. If samples remain, go to DRAIN; else go to EMIT.
- abort in RUN: latch dp_minval/dp_position, set ab, go to EMIT.
- abort and dp_done in the same cycle: dp_done wins, ab=0.
- abort in IDLE, HDR, DRAIN or EMIT is ignored.

DRAIN:
- Pops the remaining samples with rden=1 whenever !empty; dp_running=0.
- Go to EMIT after the last sample. minval is set to all-ones, position to 0.
- This preserves source-FIFO packet framing.

EMIT:
- Combinational handshake: sink_fifo_wren = (state==EMIT) && !sink_fifo_full.
- A word is accepted on any cycle with wren=1; the word index advances only on acceptance.
- Packet words, in order:
  - word 0: qid
  - word 1: position
  - word 2: {zero-pad, minval}
  - word 3: {30'b0, ab, hit}, where hit = !ab && minval<=threshold (unsigned compare)
- sink_fifo_last=1 only alongside word 3.
- On acceptance of word 3: nquery++ (wraps at 2^32), go to IDLE.
- full held asserted stalls EMIT indefinitely with no duplicate or lost words.

Test Plan:
1. sqg_len=4, ref_load_done=1, FIFO holds {0x11,s0..s3}, dp_done after 10 RUN cycles, dp_minval=0x20, dp_position=7, threshold=0x30 -> packet 0x11, 7, 0x20, 0x1 with last on word 4; nquery=1; exactly 5 pops.
2. Same as 1 with the FIFO empty for 3 cycles mid-LOAD -> dp_running=0 and addr frozen for exactly those 3 cycles; packet identical.
3. sink_fifo_full toggling 1/0 every cycle during EMIT -> exactly 4 wren pulses, words in order, no duplicates.
4. sqg_len=8, abort after 3 samples -> remaining 5 samples popped with dp_running=0; packet qid, 0, 0xFFFF, 0x2; the next query parses correctly.
5. abort and dp_done in the same RUN cycle, minval=0x40, threshold=0x10 -> flags word 0x0.
6. sqg_len=0 or MAX_SQG+1 with rs -> err_cfg single-cycle pulse, state stays IDLE, no pops. Separately, rst asserted mid-RUN -> IDLE next cycle, dp_rst=1, no packet emitted.
